inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
//  Encoder counterpart of the RV32I decode path: takes instruction fields (opcode/funct/regs/imm) on a
//  valid/ready stream, packs them into 32-bit RV32I words and writes them sequentially into instruction
//  memory through a buffered write port. Used by the test/boot loader to build programs in imem.
// PARAMETERS
//  ADDR_W      10  imem word-address width; address wraps at 2**ADDR_W
//  BASE_ADDR   0   im_addr value after reset
//  FIFO_DEPTH  4   encoded-word buffer entries (power of 2, >=2)
// PORTS
//  clk         in   1       clock; all state updates on rising edge
//  rst         in   1       synchronous, active-high reset
//  in_valid    in   1       field bundle valid
//  in_ready    out  1       encoder can accept (= buffer not full)
//  opcode      in   7       RV32I major opcode (`OPCODE_* from riscv.svh)
//  funct3      in   3       funct3
//  funct7      in   7       funct7 (R-type and shift-immediates)
//  rd/rs1/rs2  in   5 each  register indices
//  imm         in   32      immediate, byte-offset value as the decoder reconstructs it
//  addr_load   in   1       load addr_val into the write-address counter
//  addr_val    in   ADDR_W  new write address
//  im_ready    in   1       imem accepts a write this cycle
//  im_we       out  1       imem write strobe
//  im_addr     out  ADDR_W  imem word address
//  im_wdata    out  32      encoded instruction
//  err         out  1       one-cycle pulse: bundle rejected (check feature only)
//  err_cnt     out  8       saturating reject count (check feature only)
// BEHAVIOUR
//  - Reset: buffer empty, im_addr=BASE_ADDR, im_we=0, err=0, err_cnt=0, in_ready=1 the cycle after rst drops.
//  - Accept when in_valid&&in_ready; bundle encoded combinationally and pushed same edge. Latency: accepted
//    at edge N -> im_we high earliest in cycle after N. No bypass when full (in_ready=0 while full).
//  - Format from opcode: OP=R; OPIMM/LOAD/JALR=I; STORE=S; BRANCH=B; LUI/AUIPC=U; JAL=J.
//    I: imm[11:0]->[31:20]; OPIMM funct3 001/101 instead funct7->[31:25], imm[4:0]->[24:20].
//    S: imm[11:5]->[31:25], imm[4:0]->[11:7].  B: imm[12|10:5]->[31:25], imm[4:1|11]->[11:7].
//    U: imm[31:12]->[31:12].  J: imm[20|10:1|11|19:12]->[31:12]. Unused fields (rs2 in I, rd in S/B) are 0.
//  - im_we = !empty && im_ready; on im_we: pop head, im_addr increments; 2**ADDR_W-1 wraps to 0.
//  - Push and pop in same cycle: both occur, occupancy unchanged. Order strictly FIFO.
//  - addr_load: im_addr<=addr_val; overrides increment; a write in that same cycle uses the old address.
//  - rst mid-stream: buffered words discarded, nothing further written.
// CONFIGURATION
//  INST_ENC_CHECK_EN defined: bundle rejected (handshake completes, not pushed, err=1 next cycle,
//  err_cnt+1 saturating at 255) if: opcode not one of the 9 RV32I opcodes; B/J imm[0]!=0; imm not
//  sign-representable in field (I/S 12b, B 13b, J 21b); U imm[11:0]!=0.
//  Undefined: no checks; unknown opcode packed as R-type; err and err_cnt tied 0.
// STRUCTURE
//  inst_enc_pkg: fmt_t enum (FMT_R/I/S/B/U/J), gen_fmt_f(opcode), gen_inst_f(fields)->32b word,
//  imm_fits_f(imm, width). Opcode constants stay in riscv.svh.
//  Sub-module: sync_fifo (WIDTH=32, DEPTH=FIFO_DEPTH) holds encoded words.
// TESTING
//  1 add x3,x1,x2 (op 0x33,f3 0,f7 0) after reset -> im_we, im_addr 0, im_wdata 0x002081B3.
//  2 addi x1,x0,-1 -> 0xFFF00093 @0; sw x2,8(x1) -> 0x0020A423 @1.
//  3 beq x0,x0,imm=-4 -> 0xFE000EE3; jal x1,imm=2048 -> 0x001000EF.
//  4 im_ready=0, push 4 bundles -> in_ready=0, 5th held; im_ready=1 -> addrs 0..4 one per cycle, in order.
//  5 addr_load addr_val=0x3FF, push 2 -> writes at 0x3FF then 0x000.
//  6 beq imm=3: with INST_ENC_CHECK_EN -> err pulse, err_cnt=1, no im_we; without -> word written.
//  7 rst with 2 words buffered, im_ready=1 -> no im_we after reset, im_addr=BASE_ADDR, in_ready=1.

Source files
------------

// File: rtl/inst_enc_pkg.sv
// -----------------------------------------------------------------------------
// inst_enc_pkg
// Shared types and helper functions for the RV32I instruction encoder.
//   fmt_t             : instruction format selector (R/I/S/B/U/J)
//   inst_fields_t     : one field bundle as presented on the input stream
//   OPCODE_*          : the nine RV32I major opcodes
//   gen_fmt_f         : opcode -> format (unknown opcodes map to R)
//   gen_inst_f        : field bundle -> packed 32-bit instruction word
//   imm_fits_f        : is imm representable as a signed value of 'width' bits
//   bundle_reject_f   : legality check used when INST_ENC_CHECK_EN is defined
// -----------------------------------------------------------------------------
package inst_enc_pkg;

  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
  localparam logic [6:0] OPCODE_JAL    = 7'h6F;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_OPIMM  = 7'h13;
  localparam logic [6:0] OPCODE_OP     = 7'h33;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } inst_fields_t;

  function automatic fmt_t gen_fmt_f(input logic [6:0] opcode);
    fmt_t fmt;
    case (opcode)
      OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: fmt = FMT_I;
      OPCODE_STORE:                           fmt = FMT_S;
      OPCODE_BRANCH:                          fmt = FMT_B;
      OPCODE_LUI, OPCODE_AUIPC:               fmt = FMT_U;
      OPCODE_JAL:                             fmt = FMT_J;
      default:                                fmt = FMT_R;
    endcase
    return fmt;
  endfunction

  function automatic logic opcode_known_f(input logic [6:0] opcode);
    logic known;
    case (opcode)
      OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH,
      OPCODE_LOAD, OPCODE_STORE, OPCODE_OPIMM, OPCODE_OP: known = 1'b1;
      default:                                            known = 1'b0;
    endcase
    return known;
  endfunction

  function automatic logic [31:0] gen_inst_f(input inst_fields_t f);
    logic [31:0] word;
    logic [31:0] imm;
    imm = f.imm;
    case (gen_fmt_f(f.opcode))
      FMT_I: begin
        // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
        if (f.opcode == OPCODE_OPIMM && (f.funct3 == 3'b001 || f.funct3 == 3'b101))
          word = {f.funct7, imm[4:0], f.rs1, f.funct3, f.rd, f.opcode};
        else
          word = {imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      end
      FMT_S:   word = {imm[11:5], f.rs2, f.rs1, f.funct3, imm[4:0], f.opcode};
      FMT_B:   word = {imm[12], imm[10:5], f.rs2, f.rs1, f.funct3, imm[4:1], imm[11], f.opcode};
      FMT_U:   word = {imm[31:12], f.rd, f.opcode};
      FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], f.rd, f.opcode};
      default: word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
    endcase
    return word;
  endfunction

  function automatic logic imm_fits_f(input logic [31:0] imm, input int width);
    int lim;
    lim = 1 << (width - 1);
    return ($signed(imm) >= -lim) && ($signed(imm) < lim);
  endfunction

  function automatic logic bundle_reject_f(input inst_fields_t f);
    logic bad;
    bad = !opcode_known_f(f.opcode);
    case (gen_fmt_f(f.opcode))
      FMT_I, FMT_S: bad = bad || !imm_fits_f(f.imm, 12);
      FMT_B:        bad = bad || f.imm[0] || !imm_fits_f(f.imm, 13);
      FMT_J:        bad = bad || f.imm[0] || !imm_fits_f(f.imm, 21);
      FMT_U:        bad = bad || (f.imm[11:0] != 12'h000);
      default:      bad = bad;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// -----------------------------------------------------------------------------
// inst_encoder_if
// Groups the field-bundle input stream, the imem write port and the error
// outputs of the encoder.
//   master : the loader side (drives fields, addr_load, im_ready)
//   slave  : the encoder side (drives in_ready, im_*, err*)
// -----------------------------------------------------------------------------
interface inst_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_val;
  logic              im_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              err;
  logic [7:0]        err_cnt;

  modport master (
    output in_valid, opcode, funct3, funct7, rd, rs1, rs2, imm,
           addr_load, addr_val, im_ready,
    input  in_ready, im_we, im_addr, im_wdata, err, err_cnt
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7, rd, rs1, rs2, imm,
           addr_load, addr_val, im_ready,
    output in_ready, im_we, im_addr, im_wdata, err, err_cnt
  );
endinterface

// File: rtl/inst_encoder_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word fall-through head (o_data shows the
// oldest entry whenever o_empty is low).
// Ports: clk, rst (sync, active high), i_push/i_data, i_pop,
//        o_data, o_full, o_empty.
// Pushes while full and pops while empty are ignored.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra wrap bit distinguishes full from empty when indices match.
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
// Packs RV32I field bundles into 32-bit instruction words and writes them
// sequentially into instruction memory through a small FIFO.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : inst_encoder_if.slave (field stream, imem write port, err/err_cnt)
// Optional feature: INST_ENC_CHECK_EN -- when defined, illegal bundles are
// consumed but dropped, pulsing err and bumping the saturating err_cnt.
// When undefined no checks are done and err/err_cnt are held at 0.
// -----------------------------------------------------------------------------
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  inst_encoder_if.slave bus
);
  inst_fields_t      w_fields;
  logic [31:0]       w_word;
  logic              w_accept;
  logic              w_reject;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [31:0]       w_head;
  logic [ADDR_W-1:0] r_addr;

  always_comb begin
    w_fields        = '0;
    w_fields.opcode = bus.opcode;
    w_fields.funct3 = bus.funct3;
    w_fields.funct7 = bus.funct7;
    w_fields.rd     = bus.rd;
    w_fields.rs1    = bus.rs1;
    w_fields.rs2    = bus.rs2;
    w_fields.imm    = bus.imm;
  end

  assign w_word   = gen_inst_f(w_fields);
  assign w_accept = bus.in_valid && !w_full;

`ifdef INST_ENC_CHECK_EN
  assign w_reject = bundle_reject_f(w_fields);
`else
  assign w_reject = 1'b0;
`endif

  assign w_push = w_accept && !w_reject;
  // Held off during reset so a mid-stream reset stops writes immediately.
  assign w_pop  = !w_empty && bus.im_ready && !rst;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // addr_load wins over the post-write increment; a write in the same cycle
  // still goes out on the old address.
  always_ff @(posedge clk) begin
    if (rst)
      r_addr <= ADDR_W'(BASE_ADDR);
    else if (bus.addr_load)
      r_addr <= bus.addr_val;
    else if (w_pop)
      r_addr <= r_addr + 1'b1;
  end

  assign bus.in_ready = !w_full;
  assign bus.im_we    = w_pop;
  assign bus.im_addr  = r_addr;
  assign bus.im_wdata = w_head;

`ifdef INST_ENC_CHECK_EN
  logic       r_err;
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_err <= w_accept && w_reject;
      if (w_accept && w_reject && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.err     = r_err;
  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err     = 1'b0;
  assign bus.err_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
// Self-checking bench for inst_encoder: directed vector table, hand-written
// multi-cycle sequences and randomized bundles against a reference model.
// Honours INST_ENC_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_inst_encoder;
  localparam int ADDR_W = 10;
  localparam int BASE   = 0;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
    bit          rej;
  } vec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  inst_encoder_if #(.ADDR_W(ADDR_W)) bus_if ();

  inst_encoder #(
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from field positions with shifts and masks.
  function automatic logic [31:0] ref_encode(input vec_t v);
    logic [31:0] imm;
    logic [31:0] base;
    imm  = v.imm;
    base = 32'(v.op) | (32'(v.f3) << 12) | (32'(v.rs1) << 15);
    case (v.op)
      7'h13, 7'h03, 7'h67: begin
        if (v.op == 7'h13 && (v.f3 == 3'd1 || v.f3 == 3'd5))
          return base | (32'(v.rd) << 7) | ((imm & 32'h1F) << 20) | (32'(v.f7) << 25);
        return base | (32'(v.rd) << 7) | ((imm & 32'hFFF) << 20);
      end
      7'h23: return base | (32'(v.rs2) << 20) | ((imm & 32'h1F) << 7) |
                    (((imm >> 5) & 32'h7F) << 25);
      7'h63: return base | (32'(v.rs2) << 20) | (((imm >> 11) & 32'h1) << 7) |
                    (((imm >> 1) & 32'hF) << 8) | (((imm >> 5) & 32'h3F) << 25) |
                    (((imm >> 12) & 32'h1) << 31);
      7'h37, 7'h17: return 32'(v.op) | (32'(v.rd) << 7) | (imm & 32'hFFFFF000);
      7'h6F: return 32'(v.op) | (32'(v.rd) << 7) | (((imm >> 12) & 32'hFF) << 12) |
                    (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21) |
                    (((imm >> 20) & 32'h1) << 31);
      default: return base | (32'(v.rd) << 7) | (32'(v.rs2) << 20) | (32'(v.f7) << 25);
    endcase
  endfunction

  function automatic bit ref_reject(input vec_t v);
`ifdef INST_ENC_CHECK_EN
    int s;
    s = int'($signed(v.imm));
    case (v.op)
      7'h13, 7'h03, 7'h67, 7'h23: return !(s >= -2048 && s <= 2047);
      7'h63: return (v.imm[0] != 1'b0) || !(s >= -4096 && s <= 4095);
      7'h6F: return (v.imm[0] != 1'b0) || !(s >= -(1 << 20) && s < (1 << 20));
      7'h37, 7'h17: return v.imm[11:0] != 12'h000;
      7'h33: return 1'b0;
      default: return 1'b1;
    endcase
`else
    return v.op == 7'h7F && v.op != 7'h7F;
`endif
  endfunction

  // ---------------------------------------------------------------- scoreboard
  logic [31:0]       q[$];
  logic [ADDR_W-1:0] m_addr;
  bit                m_err;
  int                m_cnt;
  logic [31:0]       cur_exp;
  bit                cur_rej;

  always @(negedge clk) begin
    if (rst) begin
      chk("im_we_in_reset", 32'(bus_if.im_we), 32'd0);
      q.delete();
      m_addr = ADDR_W'(BASE);
      m_err  = 1'b0;
      m_cnt  = 0;
    end else begin
      chk("im_we", 32'(bus_if.im_we), 32'((q.size() != 0) && bus_if.im_ready));
      chk("in_ready", 32'(bus_if.in_ready), 32'(q.size() < DEPTH));
      if (bus_if.im_we && q.size() != 0) begin
        $display("write addr 0x%03h data 0x%08h", bus_if.im_addr, bus_if.im_wdata);
        chk("im_addr", 32'(bus_if.im_addr), 32'(m_addr));
        chk("im_wdata", bus_if.im_wdata, q[0]);
        void'(q.pop_front());
      end
`ifdef INST_ENC_CHECK_EN
      chk("err", 32'(bus_if.err), 32'(m_err));
      chk("err_cnt", 32'(bus_if.err_cnt), 32'(m_cnt));
`endif
      m_err = 1'b0;
      if (bus_if.addr_load)
        m_addr = bus_if.addr_val;
      else if (bus_if.im_we)
        m_addr = m_addr + 1'b1;
      if (bus_if.in_valid && bus_if.in_ready) begin
        if (cur_rej) begin
          m_err = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end else begin
          q.push_back(cur_exp);
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic send(input vec_t v);
    bit acc;
    bus_if.opcode   = v.op;
    bus_if.funct3   = v.f3;
    bus_if.funct7   = v.f7;
    bus_if.rd       = v.rd;
    bus_if.rs1      = v.rs1;
    bus_if.rs2      = v.rs2;
    bus_if.imm      = v.imm;
    cur_exp         = v.exp;
    cur_rej         = v.rej;
    bus_if.in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = bus_if.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      if (n == 199) chk("send_timeout", 32'd1, 32'd0);
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    bus_if.im_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (q.size() == 0) break;
      if (n == 99) chk("drain_timeout", 32'(q.size()), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.exp = ref_encode(v);
    v.rej = ref_reject(v);
    return v;
  endfunction

  // ---------------------------------------------------------------- stimulus
  vec_t        tbl[9];
  vec_t        v;
  logic [6:0]  ops[9];
  bit          rnd_bg;

  initial begin
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.opcode    = '0;
    bus_if.funct3    = '0;
    bus_if.funct7    = '0;
    bus_if.rd        = '0;
    bus_if.rs1       = '0;
    bus_if.rs2       = '0;
    bus_if.imm       = '0;
    bus_if.addr_load = 1'b0;
    bus_if.addr_val  = '0;
    bus_if.im_ready  = 1'b1;
    cur_exp          = '0;
    cur_rej          = 1'b0;
    rnd_bg           = 1'b0;

    // op, f3, f7, rd, rs1, rs2, imm, expected word, rejected
    tbl[0] = '{7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 32'h002081B3, 1'b0};
    tbl[1] = '{7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd5, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0};
    tbl[2] = '{7'h23, 3'd2, 7'h00, 5'd7, 5'd1, 5'd2, 32'h0000_0008, 32'h0020A423, 1'b0};
    tbl[3] = '{7'h63, 3'd0, 7'h00, 5'd9, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE000EE3, 1'b0};
    tbl[4] = '{7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h001000EF, 1'b0};
    tbl[5] = '{7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h123452B7, 1'b0};
    tbl[6] = '{7'h13, 3'd5, 7'h20, 5'd7, 5'd6, 5'd0, 32'h0000_0003, 32'h40335393, 1'b0};
    tbl[7] = '{7'h67, 3'd0, 7'h00, 5'd0, 5'd1, 5'd0, 32'h0000_0000, 32'h00008067, 1'b0};
`ifdef INST_ENC_CHECK_EN
    tbl[8] = '{7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0000_0003, 32'h00000163, 1'b1};
`else
    tbl[8] = '{7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0000_0003, 32'h00000163, 1'b0};
`endif
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_im_addr", 32'(bus_if.im_addr), 32'(BASE));
    chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    chk("rst_im_we", 32'(bus_if.im_we), 32'd0);
    chk("rst_err", 32'(bus_if.err), 32'd0);
    chk("rst_err_cnt", 32'(bus_if.err_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Directed vector table
    for (int i = 0; i < 9; i++) send(tbl[i]);
    drain();
`ifdef INST_ENC_CHECK_EN
    chk("tbl_err_cnt", 32'(bus_if.err_cnt), 32'd1);
`endif

    // Back-pressure: fill while imem stalls, fifth bundle waits
    do_reset();
    bus_if.im_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(mk(7'h13, 3'd0, 7'h00, 5'(i + 1), 5'd0, 5'd0, 32'(i)));
    @(negedge clk);
    chk("full_in_ready", 32'(bus_if.in_ready), 32'd0);
    @(posedge clk);
    #1;
    fork
      send(mk(7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'd4));
      begin
        repeat (3) @(posedge clk);
        #1;
        bus_if.im_ready = 1'b1;
      end
    join
    drain();
    chk("bp_final_addr", 32'(bus_if.im_addr), 32'd5);

    // Address load and wrap
    bus_if.addr_load = 1'b1;
    bus_if.addr_val  = 10'h3FF;
    @(posedge clk);
    #1;
    bus_if.addr_load = 1'b0;
    send(mk(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0));
    send(mk(7'h33, 3'd7, 7'h00, 5'd4, 5'd5, 5'd6, 32'd0));
    drain();
    chk("wrap_addr", 32'(bus_if.im_addr), 32'd1);

    // Reset with words still buffered
    bus_if.im_ready = 1'b0;
    send(mk(7'h13, 3'd0, 7'h00, 5'd8, 5'd0, 5'd0, 32'd8));
    send(mk(7'h13, 3'd0, 7'h00, 5'd9, 5'd0, 5'd0, 32'd9));
    rst             = 1'b1;
    bus_if.im_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus_if.in_ready), 32'd1);
    chk("midrst_im_addr", 32'(bus_if.im_addr), 32'(BASE));
    repeat (4) @(posedge clk);
    #1;

    // Randomized bundles with random imem stalls and address loads
    rnd_bg = 1'b1;
    fork
      begin
        while (rnd_bg) begin
          @(posedge clk);
          #1;
          bus_if.im_ready  = ($urandom_range(0, 3) != 0);
          bus_if.addr_load = ($urandom_range(0, 40) == 0);
          bus_if.addr_val  = ADDR_W'($urandom);
        end
        bus_if.im_ready  = 1'b1;
        bus_if.addr_load = 1'b0;
      end
      begin
        for (int n = 0; n < 300; n++) begin
          int k;
          k = int'($urandom_range(0, 9));
          v.op  = (k == 9) ? 7'($urandom) : ops[k];
          v.f3  = 3'($urandom);
          v.f7  = 7'($urandom);
          v.rd  = 5'($urandom);
          v.rs1 = 5'($urandom);
          v.rs2 = 5'($urandom);
          case (v.op)
            7'h13, 7'h03, 7'h67, 7'h23: v.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
            7'h63: v.imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
            7'h6F: v.imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
            7'h37, 7'h17: v.imm = $urandom & 32'hFFFFF000;
            default: v.imm = $urandom;
          endcase
          if (v.op == 7'h13 && (v.f3 == 3'd1 || v.f3 == 3'd5)) v.imm = 32'($urandom_range(0, 31));
          if ($urandom_range(0, 9) == 0) v.imm = $urandom;
          v.exp = ref_encode(v);
          v.rej = ref_reject(v);
          send(v);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_bg = 1'b0;
      end
    join
    drain();
    chk("end_queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
